// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: length encodings, tap masks and checker FSM states.
// Used by the PRBS checker and the PRBS_Variable generator.
package prbs_pkg;

    localparam logic [1:0] LEN_30 = 2'b00;
    localparam logic [1:0] LEN_25 = 2'b01;
    localparam logic [1:0] LEN_20 = 2'b11;

    // Bit k-1 set for each term x^k of the polynomial; bit index equals sr index.
    localparam logic [29:0] TAPS_30 = 30'h2000_0029;  // x^30 + x^6 + x^4 + x + 1
    localparam logic [29:0] TAPS_25 = 30'h0120_0000;  // x^25 + x^22 + 1
    localparam logic [29:0] TAPS_20 = 30'h0009_0000;  // x^20 + x^17 + 1

    // Register stages that belong to the selected length.
    localparam logic [29:0] SPAN_30 = 30'h3FFF_FFFF;
    localparam logic [29:0] SPAN_25 = 30'h01FF_FFFF;
    localparam logic [29:0] SPAN_20 = 30'h000F_FFFF;

    typedef enum logic {SEARCH, LOCKED} chk_state_e;

    // The unused code 2'b10 behaves as x^30.
    function automatic logic [1:0] decode_len(input logic [1:0] len);
        if (len == LEN_25 || len == LEN_20) begin
            return len;
        end
        return LEN_30;
    endfunction

    function automatic logic [29:0] tap_mask(input logic [1:0] len);
        unique case (len)
            LEN_25:  return TAPS_25;
            LEN_20:  return TAPS_20;
            default: return TAPS_30;
        endcase
    endfunction

    function automatic logic [29:0] span_mask(input logic [1:0] len);
        unique case (len)
            LEN_25:  return SPAN_25;
            LEN_20:  return SPAN_20;
            default: return SPAN_30;
        endcase
    endfunction

endpackage

// File: rtl/prbs_predictor.sv
// Combinational next-bit prediction from the PRBS shift register and length select.
// Also flags whether the active part of the register holds any one.
module prbs_predictor
    import prbs_pkg::*;
(
    input  logic [0:29] sr,
    input  logic [1:0]  longitud,
    output logic        p,
    output logic        nonzero
);

    logic [29:0] taps;
    logic [29:0] span;

    assign taps = tap_mask(decode_len(longitud));
    assign span = span_mask(decode_len(longitud));

    always_comb begin
        p       = 1'b0;
        nonzero = 1'b0;
        for (int i = 0; i < 30; i++) begin
            p       = p ^ (sr[i] & taps[i]);
            nonzero = nonzero | (sr[i] & span[i]);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to the line, then free-runs and counts bit errors.
// Optional PRBS_CHK_BITCNT_EN adds the Cuenta_Bits locked-bit counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned WINDOW     = 128,
    parameter int unsigned ERR_THRESH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Entrada,
    input  logic        Valido,
    input  logic [0:1]  Longitud,
    input  logic        Borrar,
    output logic        Bloqueado,
    output logic        Error_Bit,
    output logic [31:0] Cuenta_Errores
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0] Cuenta_Bits
`endif
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(WINDOW);
    localparam int unsigned EW = $clog2(ERR_THRESH + 1);

    chk_state_e    state_q, state_d;
    logic [0:29]   sr_q, sr_d;
    logic [1:0]    len_q;
    logic [1:0]    len_cur;
    logic [MW-1:0] match_cnt_q, match_cnt_d, match_inc;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0] err_win_q, err_win_d, err_inc;
    logic [31:0]   err_cnt_q, err_cnt_d;
    logic          err_bit_q;

    logic p;
    logic nonzero;
    logic len_chg;
    logic mismatch;
    logic match_hit;
    logic lock_hit;
    logic thresh_hit;
    logic win_wrap;
    logic locked_bit;
    logic locked_err;

    prbs_predictor u_predictor (
        .sr       (sr_q),
        .longitud (len_cur),
        .p        (p),
        .nonzero  (nonzero)
    );

    assign len_cur    = decode_len(Longitud);
    assign len_chg    = (len_cur != len_q);
    assign mismatch   = (Entrada != p);
    assign match_inc  = match_cnt_q + MW'(1);
    assign err_inc    = err_win_q + EW'(1);
    assign match_hit  = !mismatch && nonzero;
    assign lock_hit   = match_hit && (match_inc == MW'(LOCK_CNT));
    assign thresh_hit = mismatch && (err_inc == EW'(ERR_THRESH));
    assign win_wrap   = (win_cnt_q == WW'(WINDOW - 1));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a length change forces resynchronisation even without a valid bit.
    always_comb begin
        state_d = state_q;
        if (len_chg) begin
            state_d = SEARCH;
        end else if (Valido) begin
            unique case (state_q)
                SEARCH: if (lock_hit) state_d = LOCKED;
                LOCKED: if (thresh_hit) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        Bloqueado  = (state_q == LOCKED);
        locked_bit = Valido && !len_chg && (state_q == LOCKED);
        locked_err = locked_bit && mismatch;
    end

    // Datapath next state
    always_comb begin
        sr_d        = sr_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        err_win_d   = err_win_q;
        err_cnt_d   = err_cnt_q;

        // Once locked the register free-runs on its own prediction, so line errors don't propagate.
        if (Valido) begin
            sr_d = {(locked_bit ? p : Entrada), sr_q[0:28]};
        end

        if (len_chg) begin
            match_cnt_d = '0;
            win_cnt_d   = '0;
            err_win_d   = '0;
        end else if (Valido) begin
            if (state_q == SEARCH) begin
                match_cnt_d = (match_hit && !lock_hit) ? match_inc : '0;
            end else if (thresh_hit) begin
                match_cnt_d = '0;
                win_cnt_d   = '0;
                err_win_d   = '0;
            end else if (win_wrap) begin
                win_cnt_d = '0;
                err_win_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + WW'(1);
                err_win_d = mismatch ? err_inc : err_win_q;
            end
        end

        if (locked_err && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
        if (Borrar) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sr_q        <= '0;
            len_q       <= len_cur;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            err_win_q   <= '0;
            err_cnt_q   <= '0;
            err_bit_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            len_q       <= len_cur;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            err_win_q   <= err_win_d;
            err_cnt_q   <= err_cnt_d;
            err_bit_q   <= locked_err;
        end
    end

    assign Error_Bit      = err_bit_q;
    assign Cuenta_Errores = err_cnt_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (locked_bit && (bit_cnt_q != 32'hFFFF_FFFF)) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
        end
        if (Borrar) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign Cuenta_Bits = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: queue-based generator and checker reference model.
module tb_prbs_checker;

    localparam int LOCK_CNT   = 64;
    localparam int WINDOW     = 128;
    localparam int ERR_THRESH = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Entrada;
    logic        Valido;
    logic [0:1]  Longitud;
    logic        Borrar;
    logic        Bloqueado;
    logic        Error_Bit;
    logic [31:0] Cuenta_Errores;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] Cuenta_Bits;
`endif

    prbs_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Entrada        (Entrada),
        .Valido         (Valido),
        .Longitud       (Longitud),
        .Borrar         (Borrar),
        .Bloqueado      (Bloqueado),
        .Error_Bit      (Error_Bit),
        .Cuenta_Errores (Cuenta_Errores)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .Cuenta_Bits    (Cuenta_Bits)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Generator: history of emitted bits, newest first.
    bit gen[$];
    int g_len = 30;

    // Reference model of the checker.
    bit          hist[$];
    int          m_len;
    bit          m_locked;
    int          m_match;
    int          m_win;
    int          m_errwin;
    logic [31:0] m_errcnt;
    logic [31:0] m_bitcnt;
    bit          m_errbit;
    bit          seen_lock;

    function automatic int len_of(input logic [1:0] l);
        if (l == 2'b01) return 25;
        if (l == 2'b11) return 20;
        return 30;
    endfunction

    // XOR of the bits k steps back for every term x^k of the polynomial.
    function automatic bit xor_taps(input bit h[$], input int len);
        case (len)
            25:      return h[24] ^ h[21];
            20:      return h[19] ^ h[16];
            default: return h[29] ^ h[5] ^ h[3] ^ h[0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gen_seed(input logic [29:0] s);
        gen.delete();
        for (int i = 0; i < 30; i++) gen.push_back(s[i]);
    endtask

    task automatic gen_bit(output bit b);
        b = xor_taps(gen, g_len);
        gen.push_front(b);
        void'(gen.pop_back());
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 30; i++) hist.push_back(1'b0);
        m_len    = len_of(Longitud);
        m_locked = 0;
        m_match  = 0;
        m_win    = 0;
        m_errwin = 0;
        m_errcnt = 0;
        m_bitcnt = 0;
        m_errbit = 0;
    endtask

    task automatic model_step(input bit e, input bit v);
        bit change;
        bit p;
        bit guard;
        int ne;
        int len_now;
        len_now  = len_of(Longitud);
        change   = (len_now != m_len);
        m_len    = len_now;
        m_errbit = 0;
        if (change) begin
            m_locked = 0;
            m_match  = 0;
            m_win    = 0;
            m_errwin = 0;
        end
        if (v) begin
            p     = xor_taps(hist, len_now);
            guard = 0;
            for (int i = 0; i < len_now; i++) guard |= hist[i];
            if (m_locked) begin
                hist.push_front(p);
                if (m_bitcnt != 32'hFFFF_FFFF) m_bitcnt++;
                ne = m_errwin;
                if (e != p) begin
                    m_errbit = 1;
                    if (m_errcnt != 32'hFFFF_FFFF) m_errcnt++;
                    ne++;
                end
                if (ne == ERR_THRESH) begin
                    m_locked = 0;
                    m_match  = 0;
                    m_win    = 0;
                    m_errwin = 0;
                end else if (m_win == WINDOW - 1) begin
                    m_win    = 0;
                    m_errwin = 0;
                end else begin
                    m_win++;
                    m_errwin = ne;
                end
            end else begin
                hist.push_front(e);
                if (!change && e == p && guard) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1;
                        m_match  = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end
            void'(hist.pop_back());
        end
        if (Borrar) begin
            m_errcnt = 0;
            m_bitcnt = 0;
        end
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 ns later.
    task automatic tick(input bit e, input bit v);
        Entrada = e;
        Valido  = v;
        @(posedge Clk);
        if (Reset) model_reset();
        else model_step(e, v);
        #1;
        if (Bloqueado === 1'b1) seen_lock = 1;
        chk("bloqueado", 32'(Bloqueado), 32'(m_locked));
        chk("error_bit", 32'(Error_Bit), 32'(m_errbit));
        chk("cuenta_errores", Cuenta_Errores, m_errcnt);
`ifdef PRBS_CHK_BITCNT_EN
        chk("cuenta_bits", Cuenta_Bits, m_bitcnt);
`endif
        @(negedge Clk);
    endtask

    task automatic run(input int n, input bit rnd_valid);
        bit b;
        int k;
        k = 0;
        while (k < n) begin
            if (rnd_valid && $urandom_range(0, 1) == 0) begin
                tick(1'($urandom), 1'b0);
            end else begin
                gen_bit(b);
                tick(b, 1'b1);
                k++;
            end
        end
    endtask

    task automatic bad_bit();
        bit b;
        gen_bit(b);
        tick(~b, 1'b1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        bit found;
        Reset    = 1'b1;
        Entrada  = 1'b0;
        Valido   = 1'b0;
        Borrar   = 1'b0;
        Longitud = 2'b00;
        model_reset();
        @(negedge Clk);

        // Test 1: lock on x^30 and run error free.
        do_reset();
        chk("reset_bloqueado", 32'(Bloqueado), 32'd0);
        chk("reset_cuenta", Cuenta_Errores, 32'd0);
        gen_seed(30'h2CEBB394);
        g_len = 30;
        run(30 + LOCK_CNT + 1, 1'b0);
        chk("lock_by_95", 32'(Bloqueado), 32'd1);
        run(10000 - (30 + LOCK_CNT + 1), 1'b0);
        chk("clean_10000", Cuenta_Errores, 32'd0);

        // Test 2: single inverted bit.
        run(400, 1'b0);
        bad_bit();
        chk("single_pulse", 32'(Error_Bit), 32'd1);
        run(1, 1'b0);
        chk("pulse_ends", 32'(Error_Bit), 32'd0);
        chk("single_count", Cuenta_Errores, 32'd1);
        chk("still_locked", 32'(Bloqueado), 32'd1);

        // Test 3: eight errors in one window force loss of lock, then relock.
        run(300, 1'b0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_win == 10) found = 1;
            else run(1, 1'b0);
        end
        chk("window_align", 32'(found), 32'd1);
        for (int i = 0; i < ERR_THRESH; i++) begin
            if (i != 0) run($urandom_range(1, 4), 1'b0);
            bad_bit();
        end
        chk("lost_lock", 32'(Bloqueado), 32'd0);
        run(30 + LOCK_CNT, 1'b0);
        chk("relock", 32'(Bloqueado), 32'd1);

        // Test 4: reset mid-lock, then stuck-at-0 line.
        do_reset();
        chk("midlock_reset", 32'(Bloqueado), 32'd0);
        chk("midlock_cuenta", Cuenta_Errores, 32'd0);
        seen_lock = 0;
        for (int i = 0; i < 2000; i++) tick(1'b0, 1'b1);
        chk("stuck0_nolock", 32'(seen_lock), 32'd0);
        chk("stuck0_cuenta", Cuenta_Errores, 32'd0);

        // Test 5: switch x^30 -> x^25 -> x^20 with Valido toggling.
        gen_seed(30'h2CEBB394);
        g_len = 30;
        run(200, 1'b1);
        chk("lock_x30", 32'(Bloqueado), 32'd1);
        Longitud = 2'b01;
        g_len    = 25;
        run(1, 1'b0);
        chk("switch25_unlock", 32'(Bloqueado), 32'd0);
        run(300, 1'b1);
        chk("lock_x25", 32'(Bloqueado), 32'd1);
        Longitud = 2'b11;
        g_len    = 20;
        tick(1'b0, 1'b0);
        chk("switch20_unlock", 32'(Bloqueado), 32'd0);
        run(300, 1'b1);
        chk("lock_x20", 32'(Bloqueado), 32'd1);

        // Test 6: saturation and clear-wins.
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_cnt_q;
        m_errcnt = 32'hFFFF_FFFE;
        chk("forced_start", Cuenta_Errores, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            bad_bit();
            run(5, 1'b0);
        end
        chk("saturated", Cuenta_Errores, 32'hFFFF_FFFF);
        Borrar = 1'b1;
        bad_bit();
        Borrar = 1'b0;
        chk("clear_wins", Cuenta_Errores, 32'd0);
        chk("clear_pulse", 32'(Error_Bit), 32'd1);
        run(50, 1'b0);
        chk("locked_after_clear", 32'(Bloqueado), 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
        chk("bit_count_50", Cuenta_Bits, 32'd50);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
